mem_access_ctrl: RTL
====================

# mem_access_ctrl

Load/store access controller for the MIPS32 MEM stage. It takes byte-addressed requests from the pipeline: lw/lh/lhu/lb/lbu and sw/sh/sb. It drives the word-addressed data memory's `address`/`read_wire`/`write_wire`/`write_data` interface and captures `read_data`. Sub-word loads are extracted with sign or zero extension. Sub-word stores are done as read-modify-write, because the memory has word granularity only. The controller holds off the pipeline with `req_ready` while an access is in flight.

## Interface
- `MEM_WORDS`, 1048576: number of addressable memory words. Used only for bounds checking.
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  synchronous active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller idle and able to accept a request
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 = byte, 01 = half, 10 = word; 11 is an error
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-justified
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  32  load result; 0 for stores and errors
- `resp_err`  out  1  access rejected, valid with `resp_valid`
- `mem_address`  out  32  word index, equal to `req_addr >> 2`
- `mem_read_wire`  out  1  memory read strobe
- `mem_write_wire`  out  1  memory write strobe
- `mem_write_data`  out  32  memory write word
- `mem_read_data`  in  32  memory read word, valid the cycle after `mem_read_wire`

## Operation
- **Byte order:** big-endian. Byte offset 0 is bits [31:24]; half offset 0 is bits [31:16].
- **States:** IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP.
- **Accept:** a request is accepted on a rising edge with `req_valid && req_ready`. `req_ready` = (state == IDLE). All request fields are latched at accept; later changes to them are ignored.
- **Error check at accept:**
  - Half access with `addr[0]` = 1, word access with `addr[1:0]` ≠ 0, or `req_size` = 11 is an error.
  - Errored requests go IDLE → RESP with `resp_err` = 1.
  - No memory strobe is asserted for an errored request.
- **Load path:** IDLE → RD_ISSUE → RD_WAIT → RESP → IDLE.
  - RD_ISSUE: `mem_read_wire` = 1.
  - RD_WAIT: select the lane from `mem_read_data`, extend it, and register the result into `resp_rdata`.
- **Word store path:** IDLE → WR_ISSUE → RESP.
  - WR_ISSUE: `mem_write_wire` = 1 and `mem_write_data` = `req_wdata`.
- **Sub-word store path:** IDLE → RD_ISSUE → RD_WAIT → WR_ISSUE → RESP.
  - RD_WAIT merges `req_wdata[7:0]` or `req_wdata[15:0]` into the addressed lane of `mem_read_data`.
  - WR_ISSUE writes the merged word. All other lanes are preserved.
- **Strobes:** `mem_read_wire` and `mem_write_wire` are never high in the same cycle.
- **Memory-side outputs:** registered. `mem_address` is held stable from RD_ISSUE through WR_ISSUE.
- **RESP:** `resp_valid` = 1 for exactly one cycle. There is no response backpressure. The next state is IDLE.
- **Unsupported sizes:** `req_unsigned` is ignored for stores and for word loads.

## Timing
- Count from the accept edge, with cycle 1 being the first cycle after accept.
- **Latency from accept to `resp_valid`:**
  - Error: cycle 1.
  - Word store: cycle 2.
  - Load: cycle 3.
  - Sub-word store: cycle 4.
- **Back-to-back requests:** `req_ready` returns high in the cycle after RESP. The minimum request spacing is therefore latency + 1.
- **Reset:**
  - `rst_n` = 0 at an edge forces state IDLE.
  - All registered outputs go to 0: `resp_*`, `mem_*`.
  - `req_ready` = 1 from the first cycle after reset.
- **Reset mid-operation:**
  - The in-flight request is dropped and no `resp_valid` is produced.
  - A write whose WR_ISSUE cycle was already presented is committed by the memory at that same edge. It is not undone.
  - A sub-word store reset before WR_ISSUE leaves memory unchanged.

## Configuration
- Macro `MEM_BOUNDS_CHK_EN`.
- **Defined:** a request with `req_addr >> 2` ≥ `MEM_WORDS` is also an error. It gets a cycle-1 response with `resp_err` = 1 and no memory access.
- **Undefined:** no bounds check is done, and `mem_address` = `req_addr >> 2` is passed through unchanged.

## Test plan
All scenarios preload memory word 4 (byte address 0x10) with 0x80818283.
- **Byte loads:** lb at 0x11 → `resp_rdata` = 0xFFFFFF81, `resp_valid` in cycle 3, `mem_read_wire` high in cycle 1 only. lbu at 0x11 → 0x00000081.
- **Half and word loads:** lh at 0x12 → 0xFFFF8283. lhu at 0x10 → 0x00008081. lw at 0x10 → 0x80818283.
- **Sub-word stores:** sb at 0x13 with data 0x000000AA:
  - `mem_read_wire` in cycle 1; `mem_write_wire` in cycle 3 with data 0x808182AA; `resp_valid` in cycle 4.
  - A following lw at 0x10 returns 0x808182AA.
  - sh at 0x10 with data 0x1234 then gives 0x123482AA.
- **Misaligned access:** lw at 0x12 → `resp_err` = 1 and `resp_rdata` = 0 in cycle 1. No strobes are asserted. `req_ready` is high in cycle 2.
- **Reset mid-load:** `rst_n` = 0 during RD_WAIT of an lw → no `resp_valid`, all outputs 0. A subsequent lb at 0x10 completes normally with 0xFFFFFF80.
- **Bounds check:** with `MEM_WORDS` = 1024, lw at 0x1000:
  - `MEM_BOUNDS_CHK_EN` defined → `resp_err` = 1, no strobes.
  - Undefined → `mem_address` = 0x400 with `mem_read_wire` in cycle 1.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Pipeline request/response and word-addressed data-memory signals of mem_access_ctrl.
interface mem_access_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_address;
   logic        mem_read_wire;
   logic        mem_write_wire;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_address, mem_read_wire, mem_write_wire, mem_write_data
   );

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_address, mem_read_wire, mem_write_wire, mem_write_data
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// MIPS32 MEM-stage load/store controller: big-endian lanes, read-modify-write for sub-word stores.
// Response cycle 1/2/3/4 (error/word store/load/sub-word store); `MEM_BOUNDS_CHK_EN adds a word-index bounds error.
module mem_access_ctrl #(
   parameter int unsigned MEM_WORDS = 32'd1048576
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_access_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP} state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   if (MEM_WORDS == 0) begin : g_bad_cfg
      $error("mem_access_ctrl: MEM_WORDS must be nonzero");
   end

   state_e      state_q, state_d;
   logic        write_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [1:0]  off_q;
   logic [15:0] wdata_q;

   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic [31:0] mem_address_q, mem_address_d;
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;
   logic [31:0] mem_write_data_q, mem_write_data_d;

   logic        accept;
   logic        misaligned;
   logic        out_of_range;
   logic        req_err;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_val;
   logic [31:0] merged;

   assign accept = bus.req_valid && (state_q == IDLE);

   assign misaligned = ((bus.req_size == SZ_HALF) && bus.req_addr[0])
                    || ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00))
                    || (bus.req_size == 2'b11);

`ifdef MEM_BOUNDS_CHK_EN
   assign out_of_range = ({2'b00, bus.req_addr[31:2]} >= MEM_WORDS);
`else
   assign out_of_range = 1'b0;
`endif

   assign req_err = misaligned || out_of_range;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         write_q          <= 1'b0;
         size_q           <= 2'b00;
         uns_q            <= 1'b0;
         off_q            <= 2'b00;
         wdata_q          <= 16'h0;
         resp_valid_q     <= 1'b0;
         resp_err_q       <= 1'b0;
         resp_rdata_q     <= 32'h0;
         mem_address_q    <= 32'h0;
         mem_read_q       <= 1'b0;
         mem_write_q      <= 1'b0;
         mem_write_data_q <= 32'h0;
      end else begin
         state_q          <= state_d;
         resp_valid_q     <= resp_valid_d;
         resp_err_q       <= resp_err_d;
         resp_rdata_q     <= resp_rdata_d;
         mem_address_q    <= mem_address_d;
         mem_read_q       <= mem_read_d;
         mem_write_q      <= mem_write_d;
         mem_write_data_q <= mem_write_data_d;
         if (accept) begin
            write_q <= bus.req_write;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            off_q   <= bus.req_addr[1:0];
            wdata_q <= bus.req_wdata[15:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (req_err)
                  state_d = RESP;
               else if (bus.req_write && (bus.req_size == SZ_WORD))
                  state_d = WR_ISSUE;
               else
                  state_d = RD_ISSUE;
            end
         end
         RD_ISSUE: state_d = RD_WAIT;
         RD_WAIT:  state_d = write_q ? WR_ISSUE : RESP;
         WR_ISSUE: state_d = RESP;
         RESP:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state, so each strobe is high exactly in its state's cycle.
   always_comb begin
      rd_byte = bus.mem_read_data[31:24];
      case (off_q)
         2'd0:    rd_byte = bus.mem_read_data[31:24];
         2'd1:    rd_byte = bus.mem_read_data[23:16];
         2'd2:    rd_byte = bus.mem_read_data[15:8];
         default: rd_byte = bus.mem_read_data[7:0];
      endcase
      rd_half = off_q[1] ? bus.mem_read_data[15:0] : bus.mem_read_data[31:16];

      load_val = bus.mem_read_data;
      merged   = bus.mem_read_data;
      case (size_q)
         SZ_BYTE: begin
            load_val = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            case (off_q)
               2'd0:    merged[31:24] = wdata_q[7:0];
               2'd1:    merged[23:16] = wdata_q[7:0];
               2'd2:    merged[15:8]  = wdata_q[7:0];
               default: merged[7:0]   = wdata_q[7:0];
            endcase
         end
         SZ_HALF: begin
            load_val = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            if (off_q[1])
               merged[15:0] = wdata_q;
            else
               merged[31:16] = wdata_q;
         end
         default: begin
            load_val = bus.mem_read_data;
            merged   = bus.mem_read_data;
         end
      endcase

      mem_read_d       = (state_d == RD_ISSUE);
      mem_write_d      = (state_d == WR_ISSUE);
      resp_valid_d     = (state_d == RESP);
      resp_err_d       = accept && req_err;
      resp_rdata_d     = 32'h0;
      mem_address_d    = mem_address_q;
      mem_write_data_d = mem_write_data_q;

      if (accept) begin
         mem_address_d    = {2'b00, bus.req_addr[31:2]};
         mem_write_data_d = bus.req_wdata;
      end
      if (state_q == RD_WAIT) begin
         if (write_q)
            mem_write_data_d = merged;
         else
            resp_rdata_d = load_val;
      end
   end

   assign bus.req_ready      = (state_q == IDLE);
   assign bus.resp_valid     = resp_valid_q;
   assign bus.resp_err       = resp_err_q;
   assign bus.resp_rdata     = resp_rdata_q;
   assign bus.mem_address    = mem_address_q;
   assign bus.mem_read_wire  = mem_read_q;
   assign bus.mem_write_wire = mem_write_q;
   assign bus.mem_write_data = mem_write_data_q;

endmodule
